// File: rtl/user_obi_demux_ctrl.sv
// ----------------------------------------------------------------------------
// user_obi_demux_ctrl
//   Routes user-domain OBI manager requests to one of three targets:
//     idx 1 : UserRom        [0x2000_0000, 0x2000_1000)
//     idx 2 : UserSetbitacc  [0x2000_1000, 0x2000_2000)
//     idx 0 : internal error subordinate (every other address)
//   Responses return in order. While transactions are outstanding, only the
//   last-selected target may be granted. A change of target waits until the
//   outstanding count drains to zero. The request ID is held in a FIFO and
//   returned as the response ID.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   mgr_req_i / mgr_gnt_o             manager request handshake
//   mgr_addr_i/we_i/be_i/wdata_i      manager request fields
//   mgr_aid_i                         manager request ID
//   mgr_rvalid_o/rdata_o/rid_o/err_o  manager response
//   sbr_req_o[1:0] / sbr_gnt_i[1:0]   per-subordinate handshake
//                                     (bit0 UserRom, bit1 UserSetbitacc)
//   sbr_addr_o/we_o/be_o/wdata_o      broadcast copies of the request fields
//   sbr_rvalid_i/rdata_i/err_i        per-subordinate responses
//   busy_o                            transactions outstanding
// ----------------------------------------------------------------------------
module user_obi_demux_ctrl #(
  parameter int unsigned MaxTrans = 4,
  parameter int unsigned IdWidth  = 1,
  parameter logic [31:0] ErrRdata = 32'hBADCAB1E
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               mgr_req_i,
  output logic               mgr_gnt_o,
  input  logic [31:0]        mgr_addr_i,
  input  logic               mgr_we_i,
  input  logic [3:0]         mgr_be_i,
  input  logic [31:0]        mgr_wdata_i,
  input  logic [IdWidth-1:0] mgr_aid_i,
  output logic               mgr_rvalid_o,
  output logic [31:0]        mgr_rdata_o,
  output logic [IdWidth-1:0] mgr_rid_o,
  output logic               mgr_err_o,
  output logic [1:0]         sbr_req_o,
  input  logic [1:0]         sbr_gnt_i,
  output logic [31:0]        sbr_addr_o,
  output logic               sbr_we_o,
  output logic [3:0]         sbr_be_o,
  output logic [31:0]        sbr_wdata_o,
  input  logic [1:0]         sbr_rvalid_i,
  input  logic [1:0][31:0]   sbr_rdata_i,
  input  logic [1:0]         sbr_err_i,
  output logic               busy_o
);

  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxTrans);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxTrans - 1);

  typedef enum logic [1:0] {
    TgtErr = 2'd0,
    TgtRom = 2'd1,
    TgtSba = 2'd2
  } tgt_e;

  tgt_e               w_idx;
  logic               w_allow;
  logic               w_tgt_gnt;
  logic               w_hs;
  logic               w_rsp_valid;
  logic [31:0]        w_rsp_rdata;
  logic               w_rsp_err;

  logic [CntW-1:0]    r_cnt;
  tgt_e               r_sel;
  logic               r_err_pend;
  logic [PtrW-1:0]    r_wr_ptr;
  logic [PtrW-1:0]    r_rd_ptr;
  logic [IdWidth-1:0] r_fifo [MaxTrans];

  // Address decode; 4 KiB windows only need the upper 20 bits.
  // NOTE: every signal written in an always_comb gets a default on the first
  // line, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_idx = TgtErr;
    if (mgr_addr_i[31:12] == 20'h20000)      w_idx = TgtRom;
    else if (mgr_addr_i[31:12] == 20'h20001) w_idx = TgtSba;
  end

  // Same target may stack up to MaxTrans; a new target needs an empty pipe.
  // The allow term uses the registered count, so a response in this cycle
  // does not free a slot until the next one. Nothing is accepted in reset.
  assign w_allow = ~rst_i &
                   ((r_cnt == '0) | ((w_idx == r_sel) & (r_cnt < CntMax)));

  always_comb begin
    sbr_req_o = '0;
    w_tgt_gnt = 1'b1;                    // error target always accepts
    unique case (w_idx)
      TgtRom: begin
        sbr_req_o[0] = mgr_req_i & w_allow;
        w_tgt_gnt    = sbr_gnt_i[0];
      end
      TgtSba: begin
        sbr_req_o[1] = mgr_req_i & w_allow;
        w_tgt_gnt    = sbr_gnt_i[1];
      end
      default: w_tgt_gnt = 1'b1;
    endcase
  end

  assign mgr_gnt_o = mgr_req_i & w_allow & w_tgt_gnt;
  assign w_hs      = mgr_gnt_o;

  assign sbr_addr_o  = mgr_addr_i;
  assign sbr_we_o    = mgr_we_i;
  assign sbr_be_o    = mgr_be_i;
  assign sbr_wdata_o = mgr_wdata_i;

  // Only the selected source may respond; stray rvalids are dropped.
  always_comb begin
    w_rsp_valid = 1'b0;
    w_rsp_rdata = '0;
    w_rsp_err   = 1'b0;
    unique case (r_sel)
      TgtRom: begin
        w_rsp_valid = sbr_rvalid_i[0];
        w_rsp_rdata = sbr_rdata_i[0];
        w_rsp_err   = sbr_err_i[0];
      end
      TgtSba: begin
        w_rsp_valid = sbr_rvalid_i[1];
        w_rsp_rdata = sbr_rdata_i[1];
        w_rsp_err   = sbr_err_i[1];
      end
      default: begin
        w_rsp_valid = r_err_pend;
        w_rsp_rdata = ErrRdata;
        w_rsp_err   = 1'b1;
      end
    endcase
  end

  // A response with nothing outstanding would underflow the ID FIFO.
  assign mgr_rvalid_o = ~rst_i & w_rsp_valid & (r_cnt != '0);
  assign mgr_rdata_o  = mgr_rvalid_o ? w_rsp_rdata : '0;
  assign mgr_err_o    = mgr_rvalid_o & w_rsp_err;
  assign mgr_rid_o    = mgr_rvalid_o ? r_fifo[r_rd_ptr] : '0;
  assign busy_o       = (r_cnt != '0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_sel      <= TgtErr;
      r_err_pend <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_err_pend <= w_hs & (w_idx == TgtErr);
      if (w_hs) begin
        r_sel    <= w_idx;
        r_wr_ptr <= (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + 1'b1;
      end
      if (mgr_rvalid_o) begin
        r_rd_ptr <= (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + 1'b1;
      end
      unique case ({w_hs, mgr_rvalid_o})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // NOTE: the ID storage has no reset; entries are only read between a push
  // and its pop, and the pointers that define validity are reset above.
  always_ff @(posedge clk_i) begin
    if (w_hs) r_fifo[r_wr_ptr] <= mgr_aid_i;
  end

endmodule

// File: tb/tb_user_obi_demux_ctrl.sv
// ----------------------------------------------------------------------------
// tb_user_obi_demux_ctrl
//   Directed bench for user_obi_demux_ctrl (MaxTrans=4, IdWidth=1).
//   Inputs change 1 time unit after a rising edge; outputs are compared one
//   further unit later, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_user_obi_demux_ctrl;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              mgr_req_i;
  logic              mgr_gnt_o;
  logic [31:0]       mgr_addr_i;
  logic              mgr_we_i;
  logic [3:0]        mgr_be_i;
  logic [31:0]       mgr_wdata_i;
  logic [0:0]        mgr_aid_i;
  logic              mgr_rvalid_o;
  logic [31:0]       mgr_rdata_o;
  logic [0:0]        mgr_rid_o;
  logic              mgr_err_o;
  logic [1:0]        sbr_req_o;
  logic [1:0]        sbr_gnt_i;
  logic [31:0]       sbr_addr_o;
  logic              sbr_we_o;
  logic [3:0]        sbr_be_o;
  logic [31:0]       sbr_wdata_o;
  logic [1:0]        sbr_rvalid_i;
  logic [1:0][31:0]  sbr_rdata_i;
  logic [1:0]        sbr_err_i;
  logic              busy_o;

  int n_vec = 0;
  int n_err = 0;

  user_obi_demux_ctrl #(
    .MaxTrans(4),
    .IdWidth (1),
    .ErrRdata(32'hBADCAB1E)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mgr_req_i   (mgr_req_i),
    .mgr_gnt_o   (mgr_gnt_o),
    .mgr_addr_i  (mgr_addr_i),
    .mgr_we_i    (mgr_we_i),
    .mgr_be_i    (mgr_be_i),
    .mgr_wdata_i (mgr_wdata_i),
    .mgr_aid_i   (mgr_aid_i),
    .mgr_rvalid_o(mgr_rvalid_o),
    .mgr_rdata_o (mgr_rdata_o),
    .mgr_rid_o   (mgr_rid_o),
    .mgr_err_o   (mgr_err_o),
    .sbr_req_o   (sbr_req_o),
    .sbr_gnt_i   (sbr_gnt_i),
    .sbr_addr_o  (sbr_addr_o),
    .sbr_we_o    (sbr_we_o),
    .sbr_be_o    (sbr_be_o),
    .sbr_wdata_o (sbr_wdata_o),
    .sbr_rvalid_i(sbr_rvalid_i),
    .sbr_rdata_i (sbr_rdata_i),
    .sbr_err_i   (sbr_err_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [31:0] addr, input logic [0:0] aid);
    mgr_req_i  = 1'b1;
    mgr_addr_i = addr;
    mgr_aid_i  = aid;
  endtask

  task automatic idle();
    mgr_req_i    = 1'b0;
    sbr_rvalid_i = 2'b00;
    sbr_err_i    = 2'b00;
  endtask

  initial begin
    rst_i        = 1'b1;
    mgr_req_i    = 1'b0;
    mgr_addr_i   = '0;
    mgr_we_i     = 1'b0;
    mgr_be_i     = 4'hF;
    mgr_wdata_i  = '0;
    mgr_aid_i    = '0;
    sbr_gnt_i    = 2'b00;
    sbr_rvalid_i = 2'b00;
    sbr_rdata_i  = '0;
    sbr_err_i    = 2'b00;

    // ---- reset state
    tick(); tick();
    check("rst_gnt",    32'(mgr_gnt_o),    32'h0);
    check("rst_rvalid", 32'(mgr_rvalid_o), 32'h0);
    check("rst_busy",   32'(busy_o),       32'h0);
    check("rst_sbrreq", 32'(sbr_req_o),    32'h0);
    check("rst_rdata",  mgr_rdata_o,       32'h0);
    rst_i = 1'b0;
    tick();

    // ---- 1: ROM read, response next cycle
    req(32'h2000_0004, 1'b1);
    sbr_gnt_i = 2'b01;
    #1;
    check("t1_sbrreq", 32'(sbr_req_o), 32'h1);
    check("t1_gnt",    32'(mgr_gnt_o), 32'h1);
    check("t1_addr",   sbr_addr_o,     32'h2000_0004);
    tick();
    idle();
    sbr_rvalid_i   = 2'b01;
    sbr_rdata_i[0] = 32'h0000_1234;
    #1;
    check("t1_rvalid", 32'(mgr_rvalid_o), 32'h1);
    check("t1_rdata",  mgr_rdata_o,       32'h0000_1234);
    check("t1_rid",    32'(mgr_rid_o),    32'h1);
    check("t1_err",    32'(mgr_err_o),    32'h0);
    check("t1_busy",   32'(busy_o),       32'h1);
    tick();
    idle();
    #1;
    check("t1_idle", 32'(busy_o), 32'h0);

    // ---- 2: error subordinate
    req(32'h3000_0000, 1'b0);
    sbr_gnt_i = 2'b11;
    #1;
    check("t2_sbrreq", 32'(sbr_req_o), 32'h0);
    check("t2_gnt",    32'(mgr_gnt_o), 32'h1);
    tick();
    idle();
    #1;
    check("t2_rvalid", 32'(mgr_rvalid_o), 32'h1);
    check("t2_err",    32'(mgr_err_o),    32'h1);
    check("t2_rdata",  mgr_rdata_o,       32'hBADCAB1E);
    check("t2_rid",    32'(mgr_rid_o),    32'h0);
    tick();
    #1;
    check("t2_after", 32'(mgr_rvalid_o), 32'h0);

    // ---- back-to-back error requests give back-to-back responses
    req(32'h0000_0100, 1'b1);
    #1;
    check("b2b_gnt0", 32'(mgr_gnt_o), 32'h1);
    tick();
    req(32'h4000_0000, 1'b0);
    #1;
    check("b2b_gnt1",  32'(mgr_gnt_o),    32'h1);
    check("b2b_rv0",   32'(mgr_rvalid_o), 32'h1);
    check("b2b_rid0",  32'(mgr_rid_o),    32'h1);
    tick();
    idle();
    #1;
    check("b2b_rv1",  32'(mgr_rvalid_o), 32'h1);
    check("b2b_rid1", 32'(mgr_rid_o),    32'h0);
    tick();
    #1;
    check("b2b_done", 32'(busy_o), 32'h0);

    // ---- 3: four outstanding ROM reads, fifth blocked
    sbr_gnt_i   = 2'b01;
    mgr_we_i    = 1'b1;
    mgr_wdata_i = 32'hA5A5_0F0F;
    mgr_be_i    = 4'h3;
    for (int i = 0; i < 4; i++) begin
      req(32'h2000_0010 + 32'(4 * i), 1'(i));
      #1;
      check("t3_gnt", 32'(mgr_gnt_o), 32'h1);
      tick();
    end
    check("t3_wdata", sbr_wdata_o, 32'hA5A5_0F0F);
    check("t3_we",    32'(sbr_we_o), 32'h1);
    check("t3_be",    32'(sbr_be_o), 32'h3);
    mgr_we_i = 1'b0;
    req(32'h2000_0020, 1'b0);
    #1;
    check("t3_full_gnt",    32'(mgr_gnt_o), 32'h0);
    check("t3_full_sbrreq", 32'(sbr_req_o), 32'h0);
    tick();
    check("t3_full_gnt2", 32'(mgr_gnt_o), 32'h0);
    // response arrives while full: still no grant this cycle
    sbr_rvalid_i   = 2'b01;
    sbr_rdata_i[0] = 32'h0000_0100;
    #1;
    check("t3_same_gnt", 32'(mgr_gnt_o),    32'h0);
    check("t3_same_rv",  32'(mgr_rvalid_o), 32'h1);
    check("t3_same_rid", 32'(mgr_rid_o),    32'h0);
    tick();
    sbr_rvalid_i = 2'b00;
    #1;
    check("t3_freed_gnt", 32'(mgr_gnt_o), 32'h1);
    tick();
    idle();
    // remaining IDs in order: 1,0,1 then the fifth request's 0
    for (int k = 0; k < 4; k++) begin
      sbr_rvalid_i   = 2'b01;
      sbr_rdata_i[0] = 32'(k + 16);
      #1;
      check("t3_drain_rv",  32'(mgr_rvalid_o), 32'h1);
      check("t3_drain_rid", 32'(mgr_rid_o),    (k % 2 == 0) ? 32'h1 : 32'h0);
      check("t3_drain_dat", mgr_rdata_o,       32'(k + 16));
      tick();
    end
    idle();
    #1;
    check("t3_empty", 32'(busy_o), 32'h0);

    // ---- 4: target switch waits for drain
    sbr_gnt_i = 2'b11;
    req(32'h2000_0000, 1'b1);
    #1;
    check("t4_rom_gnt", 32'(mgr_gnt_o), 32'h1);
    tick();
    req(32'h2000_1000, 1'b0);
    #1;
    check("t4_wait_req", 32'(sbr_req_o), 32'h0);
    check("t4_wait_gnt", 32'(mgr_gnt_o), 32'h0);
    tick();
    check("t4_wait_req2", 32'(sbr_req_o), 32'h0);
    sbr_rvalid_i = 2'b01;
    #1;
    check("t4_rsp_req", 32'(sbr_req_o),    32'h0);
    check("t4_rsp_rv",  32'(mgr_rvalid_o), 32'h1);
    check("t4_rsp_rid", 32'(mgr_rid_o),    32'h1);
    tick();
    sbr_rvalid_i = 2'b00;
    #1;
    check("t4_sw_req", 32'(sbr_req_o), 32'h2);
    check("t4_sw_gnt", 32'(mgr_gnt_o), 32'h1);
    tick();
    idle();
    // stray ROM rvalid alongside the selected SBA response must be ignored
    sbr_rvalid_i   = 2'b11;
    sbr_rdata_i[0] = 32'hDEAD_0000;
    sbr_rdata_i[1] = 32'h0000_CAFE;
    sbr_err_i      = 2'b10;
    #1;
    check("t4_sba_rv",  32'(mgr_rvalid_o), 32'h1);
    check("t4_sba_dat", mgr_rdata_o,       32'h0000_CAFE);
    check("t4_sba_err", 32'(mgr_err_o),    32'h1);
    check("t4_sba_rid", 32'(mgr_rid_o),    32'h0);
    tick();
    idle();
    #1;
    check("t4_done", 32'(busy_o), 32'h0);

    // ---- 5: response and same-target handshake in one cycle at count 2
    req(32'h2000_1004, 1'b1);
    tick();
    req(32'h2000_1008, 1'b0);
    tick();
    req(32'h2000_100C, 1'b1);
    sbr_rvalid_i = 2'b10;
    #1;
    check("t5_gnt", 32'(mgr_gnt_o),    32'h1);
    check("t5_rv",  32'(mgr_rvalid_o), 32'h1);
    check("t5_rid", 32'(mgr_rid_o),    32'h1);
    tick();
    idle();
    sbr_rvalid_i = 2'b10;
    #1;
    check("t5_rid1", 32'(mgr_rid_o), 32'h0);
    tick();
    #1;
    check("t5_busy1", 32'(busy_o),    32'h1);
    check("t5_rid2",  32'(mgr_rid_o), 32'h1);
    tick();
    idle();
    #1;
    check("t5_busy0", 32'(busy_o), 32'h0);

    // ---- 6: reset with three outstanding
    for (int i = 0; i < 3; i++) begin
      req(32'h2000_0040, 1'b1);
      tick();
    end
    idle();
    #1;
    check("t6_busy_pre", 32'(busy_o), 32'h1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check("t6_busy", 32'(busy_o),       32'h0);
    check("t6_rv",   32'(mgr_rvalid_o), 32'h0);
    req(32'h2000_1004, 1'b1);
    #1;
    check("t6_req", 32'(sbr_req_o), 32'h2);
    check("t6_gnt", 32'(mgr_gnt_o), 32'h1);
    tick();
    idle();
    sbr_rvalid_i = 2'b10;
    #1;
    check("t6_rsp_rid", 32'(mgr_rid_o), 32'h1);
    tick();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
